// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Package : elevator_pkg
// Brief   : Shared floor constants and dispatcher state encoding.
// Rev     : 1.0
// ============================================================================
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/elevator_call_picker.sv
`default_nettype none
// ============================================================================
// Module : elevator_call_picker
// Brief  : Combinational SCAN search: nearest pending floor in the current
//          direction (current floor included), else reverse direction.
// Rev    : 1.0
// ============================================================================
module elevator_call_picker
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  dir_up,
    output logic                  found,
    output logic [FLOOR_W-1:0]    sel_floor,
    output logic                  new_dir_up
);

    logic                up_hit;
    logic                dn_hit;
    logic [FLOOR_W-1:0]  up_sel;
    logic [FLOOR_W-1:0]  dn_sel;

    // Descending sweep leaves the lowest hit at/above floor; ascending sweep
    // leaves the highest hit at/below floor, i.e. the nearest in each direction.
    always_comb begin
        up_hit = 1'b0;
        up_sel = '0;
        dn_hit = 1'b0;
        dn_sel = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) >= floor)) begin
                up_hit = 1'b1;
                up_sel = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) <= floor)) begin
                dn_hit = 1'b1;
                dn_sel = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        found      = up_hit | dn_hit;
        sel_floor  = '0;
        new_dir_up = dir_up;
        if (dir_up) begin
            if (up_hit) begin
                sel_floor = up_sel;
            end else if (dn_hit) begin
                sel_floor  = dn_sel;
                new_dir_up = 1'b0;
            end
        end else begin
            if (dn_hit) begin
                sel_floor = dn_sel;
            end else if (up_hit) begin
                sel_floor  = up_sel;
                new_dir_up = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/elevator_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module : elevator_call_dispatcher
// Brief  : Latches hall calls, issues SCAN-ordered floor requests, waits for
//          arrival plus a dwell time, then retires and counts each call.
// Rev    : 1.0
// ============================================================================
module elevator_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
    parameter int DWELL_CYCLES = 3,
    parameter int CNT_W        = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  stop,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  busy,
    output logic [CNT_W-1:0]      served_count
);

    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    state_t                state_q,   state_d;
    logic [FLOOR_W-1:0]    target_q,  target_d;
    logic                  req_q,     req_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  dir_up_q,  dir_up_d;
    logic [CNT_W-1:0]      served_q,  served_d;
    logic [DW_W-1:0]       dwell_q,   dwell_d;

    logic                  pick_found;
    logic [FLOOR_W-1:0]    pick_floor;
    logic                  pick_dir_up;

    elevator_call_picker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_picker (
        .pending    (pending_q),
        .floor      (floor),
        .dir_up     (dir_up_q),
        .found      (pick_found),
        .sel_floor  (pick_floor),
        .new_dir_up (pick_dir_up)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            target_q  <= '0;
            req_q     <= 1'b0;
            pending_q <= '0;
            dir_up_q  <= 1'b1;
            served_q  <= '0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            dir_up_q  <= dir_up_d;
            served_q  <= served_d;
            dwell_q   <= dwell_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        req_d     = req_q;
        pending_d = pending_q | call_btn;
        dir_up_d  = dir_up_q;
        served_d  = served_q;
        dwell_d   = dwell_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    target_d = pick_floor;
                    dir_up_d = pick_dir_up;
                    req_d    = 1'b1;
                    state_d  = MOVE;
                end
            end
            MOVE: begin
                if ((floor == target_q) && !stop) begin
                    dwell_d = DW_W'(DWELL_CYCLES - 1);
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (!stop) begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - DW_W'(1);
                    end else begin
                        // Applied after the OR so a same-cycle press of this floor is dropped.
                        pending_d[target_q] = 1'b0;
                        served_d            = served_q + CNT_W'(1);
                        req_d               = 1'b0;
                        state_d             = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign target_floor = target_q;
    assign req_valid    = req_q;
    assign pending      = pending_q;
    assign dir_up       = dir_up_q;
    assign busy         = (state_q != IDLE);
    assign served_count = served_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module : tb_elevator_call_dispatcher
// Brief  : Directed scenarios plus randomized traffic against a behavioural
//          call-dispatch model.
// Rev    : 1.0
// ============================================================================
module tb_elevator_call_dispatcher;

    localparam int DWELL = 3;

    logic       clock;
    logic       reset;
    logic [3:0] call_btn;
    logic [1:0] floor;
    logic       stop;
    logic [1:0] target_floor;
    logic       req_valid;
    logic [3:0] pending;
    logic       dir_up;
    logic       busy;
    logic [3:0] served_count;

    int checks = 0;
    int errors = 0;

    elevator_call_dispatcher #(
        .NUM_FLOORS   (4),
        .FLOOR_W      (2),
        .DWELL_CYCLES (DWELL),
        .CNT_W        (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .call_btn     (call_btn),
        .floor        (floor),
        .stop         (stop),
        .target_floor (target_floor),
        .req_valid    (req_valid),
        .pending      (pending),
        .dir_up       (dir_up),
        .busy         (busy),
        .served_count (served_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = waiting for calls, 1 = travelling, 2 = dwelling
    logic [3:0] m_pend;
    int         m_phase;
    int         m_target;
    bit         m_req;
    bit         m_dir;
    int         m_count;
    int         m_elapsed;

    function automatic int scan(input int fl, input bit up, input logic [3:0] p);
        int f;
        for (int d = 0; d < 4; d++) begin
            f = up ? fl + d : fl - d;
            if (f >= 0 && f < 4) begin
                if (p[f]) return f;
            end
        end
        return -1;
    endfunction

    always @(posedge clock or posedge reset) begin
        logic [3:0] nxt;
        int         s;
        if (reset) begin
            m_pend = 4'b0; m_phase = 0; m_target = 0; m_req = 0;
            m_dir = 1; m_count = 0; m_elapsed = 0;
        end else begin
            nxt = m_pend | call_btn;
            if (m_phase == 0) begin
                if (m_pend != 4'b0) begin
                    s = scan(int'(floor), m_dir, m_pend);
                    if (s < 0) begin
                        m_dir = !m_dir;
                        s = scan(int'(floor), m_dir, m_pend);
                    end
                    m_target = s;
                    m_req    = 1;
                    m_phase  = 1;
                end
            end else if (m_phase == 1) begin
                if (int'(floor) == m_target && !stop) begin
                    m_phase   = 2;
                    m_elapsed = 0;
                end
            end else begin
                if (!stop) begin
                    m_elapsed++;
                    if (m_elapsed == DWELL) begin
                        nxt[m_target] = 1'b0;
                        m_count = (m_count + 1) % 16;
                        m_req   = 0;
                        m_phase = 0;
                    end
                end
            end
            m_pend = nxt;
        end
    end

    always @(negedge clock) begin
        chk("target_floor", int'(target_floor), m_target);
        chk("req_valid",    int'(req_valid),    int'(m_req));
        chk("pending",      int'(pending),      int'(m_pend));
        chk("dir_up",       int'(dir_up),       int'(m_dir));
        chk("busy",         int'(busy),         (m_phase != 0) ? 1 : 0);
        chk("served_count", int'(served_count), m_count);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [3:0] b);
        call_btn = b;
        tick(1);
        call_btn = 4'b0;
    endtask

    initial begin
        reset = 1'b1; call_btn = 4'b0; floor = 2'd0; stop = 1'b0;
        tick(2);
        chk("rst_target", int'(target_floor), 0);
        chk("rst_req",    int'(req_valid), 0);
        chk("rst_dir",    int'(dir_up), 1);
        chk("rst_busy",   int'(busy), 0);
        reset = 1'b0;

        // Call to the top floor from the ground floor
        call_btn = 4'b1000;
        tick(1);
        call_btn = 4'b0;
        chk("t1_pending", int'(pending), 8);
        chk("t1_req_lat", int'(req_valid), 0);
        tick(1);
        chk("t1_req",    int'(req_valid), 1);
        chk("t1_target", int'(target_floor), 3);
        chk("t1_dir",    int'(dir_up), 1);
        chk("t1_model_target", m_target, 3);

        // Arrival and dwell
        floor = 2'd3;
        tick(3);
        chk("t2_still_busy", int'(busy), 1);
        tick(1);
        chk("t2_busy",    int'(busy), 0);
        chk("t2_served",  int'(served_count), 1);
        chk("t2_pending", int'(pending), 0);
        chk("t2_req",     int'(req_valid), 0);

        // Reversal: nothing above floor 2, nearest below is 1
        floor = 2'd2;
        press(4'b0011);
        tick(1);
        chk("t3_target", int'(target_floor), 1);
        chk("t3_dir",    int'(dir_up), 0);
        floor = 2'd1;
        tick(5);
        chk("t3_next_target", int'(target_floor), 0);
        chk("t3_next_req",    int'(req_valid), 1);
        chk("t3_served",      int'(served_count), 2);
        floor = 2'd0;
        tick(4);
        chk("t3_done", int'(served_count), 3);

        // Stop held in MOVE and mid-DWELL
        press(4'b0100);
        tick(1);
        chk("t4_target", int'(target_floor), 2);
        chk("t4_dir",    int'(dir_up), 1);
        floor = 2'd2; stop = 1'b1;
        tick(2);
        stop = 1'b0;
        tick(2);
        stop = 1'b1;
        tick(3);
        chk("t4_frozen", int'(busy), 1);
        stop = 1'b0;
        tick(1);
        chk("t4_last_dwell", int'(busy), 1);
        tick(1);
        chk("t4_retired", int'(busy), 0);
        chk("t4_served",  int'(served_count), 4);

        // Press of the served floor on the retire cycle is dropped
        press(4'b0010);
        tick(1);
        chk("t5_target", int'(target_floor), 1);
        floor = 2'd1;
        tick(3);
        call_btn = 4'b0010;
        tick(1);
        call_btn = 4'b0;
        chk("t5_clear_wins", int'(pending), 0);
        chk("t5_served",     int'(served_count), 5);
        tick(1);
        chk("t5_stays_idle", int'(busy), 0);
        for (int k = 0; k < 11; k++) begin
            press(4'b0010);
            tick(5);
        end
        chk("t5_wrap", int'(served_count), 0);

        // Asynchronous reset in the middle of MOVE
        floor = 2'd0;
        press(4'b0110);
        tick(1);
        floor = 2'd3;
        tick(1);
        chk("t6_moving", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_target",  int'(target_floor), 0);
        chk("t6_req",     int'(req_valid), 0);
        chk("t6_pending", int'(pending), 0);
        chk("t6_dir",     int'(dir_up), 1);
        chk("t6_busy",    int'(busy), 0);
        chk("t6_served",  int'(served_count), 0);
        tick(1);
        reset = 1'b0;
        tick(2);
        chk("t6_idle", int'(busy), 0);

        // Randomized traffic with a crude elevator that drifts toward the target
        for (int c = 0; c < 4000; c++) begin
            call_btn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            stop     = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 60) == 0) begin
                floor = 2'($urandom_range(0, 3));
            end else if (m_req && $urandom_range(0, 2) == 0) begin
                if (int'(floor) < m_target)      floor = floor + 2'd1;
                else if (int'(floor) > m_target) floor = floor - 2'd1;
            end
            reset = ($urandom_range(0, 700) == 0);
            tick(1);
        end
        reset = 1'b0;
        call_btn = 4'b0;
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
